// File: rtl/data_mem_lsu_pkg.sv
// Shared funct3 codes and access-size decode for the data memory load/store unit.
// dmem_size returns the access size in bytes, or 0 for a code illegal at this width.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_D  = 3'b011;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;
   localparam logic [2:0] F3_WU = 3'b110;

   function automatic logic [3:0] dmem_size(input logic [2:0] f3, input logic is64);
      case (f3)
         F3_B, F3_BU: return 4'd1;
         F3_H, F3_HU: return 4'd2;
         F3_W:        return 4'd4;
         F3_D:        return is64 ? 4'd8 : 4'd0;
         F3_WU:       return is64 ? 4'd4 : 4'd0;
         default:     return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus between the core data port and the load/store unit.
// The core drives the master side; data_mem_lsu is the slave.
interface data_mem_lsu_if #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 10,
   parameter int ERR_CNT_WIDTH = 16
);
   logic                     req_valid;
   logic                     req_we;
   logic [2:0]               req_funct3;
   logic [ADDR_WIDTH-1:0]    req_addr;
   logic [DATA_WIDTH-1:0]    req_wdata;
   logic                     rsp_valid;
   logic [DATA_WIDTH-1:0]    rsp_rdata;
   logic                     rsp_err;
   logic [ERR_CNT_WIDTH-1:0] err_count;

   modport master (
      output req_valid, req_we, req_funct3, req_addr, req_wdata,
      input  rsp_valid, rsp_rdata, rsp_err, err_count
   );

   modport slave (
      input  req_valid, req_we, req_funct3, req_addr, req_wdata,
      output rsp_valid, rsp_rdata, rsp_err, err_count
   );
endinterface

// File: rtl/data_mem_lsu_bank.sv
// Byte-enabled synchronous RAM with a registered read address; contents are never reset.
// A write and a later read of the same word see the new data on the next cycle.
module dmem_bank #(
   parameter int DATA_WIDTH = 32,
   parameter int WORD_AW    = 8
) (
   input  logic                    clk,
   input  logic [DATA_WIDTH/8-1:0] we_be,
   input  logic [WORD_AW-1:0]      word_addr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   output logic [DATA_WIDTH-1:0]   rdata
);
   localparam int NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [2**WORD_AW];
   logic [WORD_AW-1:0]    raddr_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NB; i++) begin
         if (we_be[i]) begin
            mem[word_addr][i*8 +: 8] <= wdata[i*8 +: 8];
         end
      end
      raddr_q <= word_addr;
   end

   assign rdata = mem[raddr_q];

endmodule

// File: rtl/data_mem_lsu.sv
// RISC-V load/store front end over a byte-enabled data RAM: size decode, alignment check,
// write steering, one-cycle load response with extension, and a saturating error counter.
module data_mem_lsu
   import dmem_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 10,
   parameter int ERR_CNT_WIDTH = 16
) (
   input  logic           clk,
   input  logic           rst,
   data_mem_lsu_if.slave  bus
);
   localparam int   NB      = DATA_WIDTH / 8;
   localparam int   OFF_W   = $clog2(NB);
   localparam int   WORD_AW = ADDR_WIDTH - OFF_W;
   localparam logic IS64    = (DATA_WIDTH == 64);

   logic [OFF_W-1:0]      req_off;
   logic [WORD_AW-1:0]    req_word;
   logic [3:0]            req_size;
   logic [3:0]            off_ext;
   logic                  illegal;
   logic                  misaligned;
   logic                  req_err;
   logic [NB-1:0]         size_mask;
   logic [NB-1:0]         we_be;
   logic [DATA_WIDTH-1:0] wdata_sh;
   logic [DATA_WIDTH-1:0] bank_rdata;

   assign req_off  = bus.req_addr[OFF_W-1:0];
   assign req_word = bus.req_addr[ADDR_WIDTH-1:OFF_W];
   assign req_size = dmem_size(bus.req_funct3, IS64);
   assign off_ext  = 4'(req_off);

   // Unsigned codes (1xx) have no meaning for stores.
   assign illegal    = (req_size == 4'd0) || (bus.req_we && bus.req_funct3[2]);
   assign misaligned = |(off_ext & (req_size - 4'd1));
   assign req_err    = bus.req_valid && (illegal || misaligned);

   genvar gi;
   generate
      for (gi = 0; gi < NB; gi++) begin : g_mask
         assign size_mask[gi] = (4'(gi) < req_size);
      end
   endgenerate

   assign we_be    = (bus.req_valid && bus.req_we && !req_err) ? (size_mask << req_off) : '0;
   assign wdata_sh = bus.req_wdata << {req_off, 3'b000};

   dmem_bank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WORD_AW    (WORD_AW)
   ) u_bank (
      .clk       (clk),
      .we_be     (we_be),
      .word_addr (req_word),
      .wdata     (wdata_sh),
      .rdata     (bank_rdata)
   );

   logic                     rsp_valid_q;
   logic                     rsp_err_q;
   logic                     we_q;
   logic [OFF_W-1:0]         off_q;
   logic [2:0]               f3_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_q;
   logic [ERR_CNT_WIDTH-1:0] err_cnt_d;

   assign err_cnt_d = (req_err && (err_cnt_q != '1)) ? err_cnt_q + ERR_CNT_WIDTH'(1) : err_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         we_q        <= 1'b0;
         off_q       <= '0;
         f3_q        <= '0;
         err_cnt_q   <= '0;
      end else begin
         rsp_valid_q <= bus.req_valid;
         rsp_err_q   <= req_err;
         we_q        <= bus.req_we;
         off_q       <= req_off;
         f3_q        <= bus.req_funct3;
         err_cnt_q   <= err_cnt_d;
      end
   end

   logic [DATA_WIDTH-1:0] rd_sh;
   logic [DATA_WIDTH-1:0] rd_ext;

   assign rd_sh = bank_rdata >> {off_q, 3'b000};

   always_comb begin
      rd_ext = rd_sh;
      case (f3_q)
         F3_B:    rd_ext = DATA_WIDTH'($signed(rd_sh[7:0]));
         F3_BU:   rd_ext = DATA_WIDTH'(rd_sh[7:0]);
         F3_H:    rd_ext = DATA_WIDTH'($signed(rd_sh[15:0]));
         F3_HU:   rd_ext = DATA_WIDTH'(rd_sh[15:0]);
         F3_W:    rd_ext = DATA_WIDTH'($signed(rd_sh[31:0]));
         F3_WU:   rd_ext = DATA_WIDTH'(rd_sh[31:0]);
         default: rd_ext = rd_sh;
      endcase
   end

   // Only a successful load carries data; stores, errors and idle cycles read as zero.
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.rsp_rdata = (rsp_valid_q && !we_q && !rsp_err_q) ? rd_ext : '0;
   assign bus.err_count = err_cnt_q;

endmodule

// File: tb/tb_data_mem_lsu.sv
// Directed bench: a 32-bit instance and a 2-bit-counter instance share one request stream
// from a vector table; a 64-bit instance is exercised with hand-written sequences.
module tb_data_mem_lsu;
   import dmem_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        r_valid = 1'b0;
   logic        r_we = 1'b0;
   logic [2:0]  r_f3 = 3'b000;
   logic [9:0]  r_addr = '0;
   logic [63:0] r_wdata = '0;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   data_mem_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(16)) if32 ();
   data_mem_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(2))  ifs  ();
   data_mem_lsu_if #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(16)) if64 ();

   assign if32.req_valid  = r_valid;
   assign if32.req_we     = r_we;
   assign if32.req_funct3 = r_f3;
   assign if32.req_addr   = r_addr;
   assign if32.req_wdata  = r_wdata[31:0];
   assign ifs.req_valid   = r_valid;
   assign ifs.req_we      = r_we;
   assign ifs.req_funct3  = r_f3;
   assign ifs.req_addr    = r_addr;
   assign ifs.req_wdata   = r_wdata[31:0];
   assign if64.req_valid  = r_valid;
   assign if64.req_we     = r_we;
   assign if64.req_funct3 = r_f3;
   assign if64.req_addr   = r_addr;
   assign if64.req_wdata  = r_wdata;

   data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(16)) dut32 (
      .clk (clk), .rst (rst), .bus (if32.slave));
   data_mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(2)) dut_sat (
      .clk (clk), .rst (rst), .bus (ifs.slave));
   data_mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .ERR_CNT_WIDTH(16)) dut64 (
      .clk (clk), .rst (rst), .bus (if64.slave));

   typedef struct {
      logic        valid;
      logic        we;
      logic [2:0]  f3;
      logic [9:0]  addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
      int          cnt;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic valid, input logic we, input logic [2:0] f3,
                               input logic [9:0] addr, input logic [31:0] wdata,
                               input logic err, input logic [31:0] rdata, input int cnt);
      vec_t v;
      v = '{valid, we, f3, addr, wdata, err, rdata, cnt};
      tbl.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one request (or idle cycle) and advance to the next falling edge,
   // where the response to that request is visible.
   task automatic step(input logic valid, input logic we, input logic [2:0] f3,
                       input logic [9:0] addr, input logic [63:0] wdata);
      r_valid = valid;
      r_we    = we;
      r_f3    = f3;
      r_addr  = addr;
      r_wdata = wdata;
      @(negedge clk);
   endtask

   initial begin
      // valid we f3 addr wdata | err rdata cnt
      add(1, 1, F3_W,   10'h010, 32'hDEADBEEF, 0, 32'h0,        0);
      add(1, 0, F3_W,   10'h010, 32'h0,        0, 32'hDEADBEEF, 0);
      add(1, 1, F3_B,   10'h013, 32'h00000080, 0, 32'h0,        0);
      add(1, 0, F3_B,   10'h013, 32'h0,        0, 32'hFFFFFF80, 0);
      add(1, 0, F3_BU,  10'h013, 32'h0,        0, 32'h00000080, 0);
      add(1, 0, F3_W,   10'h010, 32'h0,        0, 32'h80ADBEEF, 0);
      add(1, 1, F3_H,   10'h011, 32'h00001234, 1, 32'h0,        1);
      add(1, 0, F3_W,   10'h010, 32'h0,        0, 32'h80ADBEEF, 1);
      add(1, 0, F3_W,   10'h012, 32'h0,        1, 32'h0,        2);
      add(0, 0, F3_W,   10'h010, 32'h0,        0, 32'h0,        2);
      add(1, 1, F3_W,   10'h020, 32'h11112222, 0, 32'h0,        2);
      add(1, 0, F3_W,   10'h020, 32'h0,        0, 32'h11112222, 2);
      add(1, 1, F3_H,   10'h022, 32'h0000ABCD, 0, 32'h0,        2);
      add(1, 0, F3_W,   10'h020, 32'h0,        0, 32'hABCD2222, 2);
      add(1, 0, F3_H,   10'h022, 32'h0,        0, 32'hFFFFABCD, 2);
      add(1, 0, F3_HU,  10'h022, 32'h0,        0, 32'h0000ABCD, 2);
      add(1, 0, F3_B,   10'h020, 32'h0,        0, 32'h00000022, 2);
      add(1, 1, F3_W,   10'h024, 32'hCAFEF00D, 0, 32'h0,        2);
      add(1, 0, 3'b111, 10'h020, 32'h0,        1, 32'h0,        3);
      add(1, 1, F3_BU,  10'h024, 32'h000000FF, 1, 32'h0,        4);
      add(1, 1, F3_HU,  10'h024, 32'h0000FFFF, 1, 32'h0,        5);
      add(1, 0, F3_W,   10'h024, 32'h0,        0, 32'hCAFEF00D, 5);
      add(1, 0, F3_H,   10'h021, 32'h0,        1, 32'h0,        6);
      add(1, 1, F3_B,   10'h026, 32'h0000007F, 0, 32'h0,        6);
      add(1, 0, F3_B,   10'h026, 32'h0,        0, 32'h0000007F, 6);
      add(1, 0, F3_W,   10'h024, 32'h0,        0, 32'hCA7FF00D, 6);
      add(1, 0, F3_H,   10'h026, 32'h0,        0, 32'hFFFFCA7F, 6);
      add(0, 1, F3_W,   10'h024, 32'h00000000, 0, 32'h0,        6);
      add(1, 0, F3_W,   10'h024, 32'h0,        0, 32'hCA7FF00D, 6);

      // Outputs held at zero while reset is asserted, even with a request presented.
      r_valid = 1'b1;
      r_f3    = F3_W;
      repeat (2) @(negedge clk);
      chk("reset rsp_valid32", 64'(if32.rsp_valid), 64'h0);
      chk("reset rsp_err32",   64'(if32.rsp_err),   64'h0);
      chk("reset rdata32",     64'(if32.rsp_rdata), 64'h0);
      chk("reset errcnt32",    64'(if32.err_count), 64'h0);
      chk("reset rsp_valid64", 64'(if64.rsp_valid), 64'h0);
      chk("reset rdata64",     if64.rsp_rdata,      64'h0);
      r_valid = 1'b0;
      rst     = 1'b0;

      for (int i = 0; i < tbl.size(); i++) begin
         int sat;
         step(tbl[i].valid, tbl[i].we, tbl[i].f3, tbl[i].addr, 64'(tbl[i].wdata));
         sat = (tbl[i].cnt > 3) ? 3 : tbl[i].cnt;
         $display("[TB] vec %0d v=%0b we=%0b f3=%03b addr=%03h -> rv=%0b err=%0b rdata=%08h cnt=%0d sat=%0d",
                  i, tbl[i].valid, tbl[i].we, tbl[i].f3, tbl[i].addr, if32.rsp_valid,
                  if32.rsp_err, if32.rsp_rdata, if32.err_count, ifs.err_count);
         chk($sformatf("vec%0d rsp_valid", i), 64'(if32.rsp_valid), 64'(tbl[i].valid));
         chk($sformatf("vec%0d rsp_err", i),   64'(if32.rsp_err),   64'(tbl[i].err));
         chk($sformatf("vec%0d rsp_rdata", i), 64'(if32.rsp_rdata), 64'(tbl[i].rdata));
         chk($sformatf("vec%0d err_count", i), 64'(if32.err_count), 64'(tbl[i].cnt));
         chk($sformatf("vec%0d sat_count", i), 64'(ifs.err_count),  64'(sat));
      end

      // 64-bit instance: doubleword store, word loads with both extensions.
      step(1, 1, F3_D, 10'h008, 64'h0123456789ABCDEF);
      $display("[TB] SD 008 -> rv=%0b err=%0b rdata=%016h", if64.rsp_valid, if64.rsp_err, if64.rsp_rdata);
      chk("sd64 rsp_valid", 64'(if64.rsp_valid), 64'h1);
      chk("sd64 rsp_err",   64'(if64.rsp_err),   64'h0);
      chk("sd64 rsp_rdata", if64.rsp_rdata,      64'h0);
      step(1, 0, F3_WU, 10'h00C, 64'h0);
      $display("[TB] LWU 00C -> rdata=%016h", if64.rsp_rdata);
      chk("lwu64 rdata", if64.rsp_rdata, 64'h0000000001234567);
      step(1, 0, F3_W, 10'h008, 64'h0);
      $display("[TB] LW 008 -> rdata=%016h", if64.rsp_rdata);
      chk("lw64 rdata", if64.rsp_rdata, 64'hFFFFFFFF89ABCDEF);
      step(1, 0, F3_D, 10'h008, 64'h0);
      $display("[TB] LD 008 -> rdata=%016h", if64.rsp_rdata);
      chk("ld64 rdata", if64.rsp_rdata, 64'h0123456789ABCDEF);
      step(1, 1, F3_W, 10'h00C, 64'h00000000AABBCCDD);
      $display("[TB] SW 00C -> rv=%0b err=%0b", if64.rsp_valid, if64.rsp_err);
      chk("sw64 rsp_err", 64'(if64.rsp_err), 64'h0);
      step(1, 0, F3_D, 10'h008, 64'h0);
      $display("[TB] LD 008 -> rdata=%016h", if64.rsp_rdata);
      chk("ld64 after sw", if64.rsp_rdata, 64'hAABBCCDD89ABCDEF);
      step(1, 0, F3_W, 10'h00A, 64'h0);
      $display("[TB] LW 00A -> err=%0b rdata=%016h", if64.rsp_err, if64.rsp_rdata);
      chk("lw64 misaligned err",   64'(if64.rsp_err), 64'h1);
      chk("lw64 misaligned rdata", if64.rsp_rdata,    64'h0);

      // Reset lands right after a load is registered: its response is dropped.
      r_valid = 1'b1;
      r_we    = 1'b0;
      r_f3    = F3_D;
      r_addr  = 10'h008;
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      $display("[TB] reset after LD -> rv=%0b rdata=%016h cnt=%0d", if64.rsp_valid, if64.rsp_rdata, if64.err_count);
      chk("rst drop rsp_valid", 64'(if64.rsp_valid), 64'h0);
      chk("rst drop rdata",     if64.rsp_rdata,      64'h0);
      chk("rst errcnt64",       64'(if64.err_count), 64'h0);
      r_valid = 1'b0;
      rst     = 1'b0;
      @(negedge clk);
      step(1, 0, F3_D, 10'h008, 64'h0);
      $display("[TB] LD 008 after reset -> rv=%0b rdata=%016h", if64.rsp_valid, if64.rsp_rdata);
      chk("post-rst rsp_valid", 64'(if64.rsp_valid), 64'h1);
      chk("post-rst rdata",     if64.rsp_rdata,      64'hAABBCCDD89ABCDEF);
      step(0, 0, F3_B, 10'h000, 64'h0);
      chk("idle rsp_valid64", 64'(if64.rsp_valid), 64'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/data_mem_lsu.md
# data_mem_lsu

Parametrised data memory with a RISC-V load/store unit front end for the single-cycle core. It accepts byte-addressed requests with byte, half, word (and, at 64 bits, double) access sizes, and applies byte-enable writes. It returns sign- or zero-extended load data one cycle later, with a misalignment/illegal-size error response. It replaces the plain word RAM on the core's data port and adds a saturating error counter for debug.

## Interface
- DATA_WIDTH, 32, memory word width; legal values 32 or 64
- ADDR_WIDTH, 10, byte-address width; depth = 2**ADDR_WIDTH / (DATA_WIDTH/8) words
- ERR_CNT_WIDTH, 16, width of saturating error counter

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present this cycle
- req_we  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3 size/sign code
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-aligned (LSBs)
- rsp_valid  out  1  response for request issued previous cycle
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  1  request was misaligned or illegal funct3
- err_count  out  ERR_CNT_WIDTH  number of errored requests, saturating

## Operation
- funct3 decode: 000 B, 001 H, 010 W, 100 BU, 101 HU; only at DATA_WIDTH=64, also 011 D and 110 WU. Any other code, including store with 1xx, is illegal.
- Word index = req_addr >> log2(DATA_WIDTH/8); byte offset = low log2(DATA_WIDTH/8) bits.
- Alignment: H requires offset[0]=0, W requires offset[1:0]=0, D requires offset[2:0]=0. B is always aligned.
- Store, legal and aligned: req_wdata LSBs are shifted to offset × 8. Byte enables cover exactly the access size. Unselected bytes are unchanged.
- Store, error: no byte written.
- Load, legal and aligned: the selected bytes are extracted from the registered word and shifted to bit 0. Extension is sign extension for B/H/W and zero extension for BU/HU/WU. D returns the full word.
- Any error: rsp_err=1 and rsp_rdata=0. err_count increments by 1 and holds at all-ones.
- Memory contents are not reset and are undefined until written.

## Timing
- Reset values: rsp_valid=0, rsp_err=0, rsp_rdata=0, err_count=0. Internal registered offset/funct3/we are cleared.
- Reset asserted mid-operation: any pending response is dropped. A write already committed on an earlier edge persists.
- Store: the array updates on the edge where req_valid=1. rsp_valid=1 on the following cycle with rsp_rdata=0.
- Load: address and control are registered on the request edge. rsp_valid and rsp_rdata are valid in the next cycle; latency is 1.
- Back-to-back requests every cycle are supported, with no stall and no ready signal.
- A load on the cycle after a store to the same word returns the newly written data.
- req_valid=0: no write occurs, and rsp_valid=0 next cycle. rsp_rdata and rsp_err return to 0 when rsp_valid=0.
- err_count updates on the request edge and is visible the same cycle as the errored response.

## Structure
- Package dmem_pkg holds the funct3 localparams (F3_B, F3_H, F3_W, F3_D, F3_BU, F3_HU, F3_WU) and a size-decode function returning the byte count.
- Sub-module dmem_bank is the byte-enabled synchronous RAM. It has the ports clk, we_be[DATA_WIDTH/8], word_addr, wdata and rdata, with a registered read address. The bank has no reset.
- The top level contains the decode, alignment check, write steering, response registers, load extension and error counter.

## Test plan
- After reset, SW 0xDEADBEEF to 0x010, then LW 0x010: the next-cycle response is rdata=0xDEADBEEF, err=0. All outputs read 0 during reset.
- SB 0x80 to 0x013, then LB 0x013 → 0xFFFFFF80, and LBU 0x013 → 0x00000080. LW 0x010 → 0x80ADBEEF.
- SH 0x1234 to 0x011 → rsp_err=1, word at 0x010 unchanged, err_count=1. LW 0x012 → rsp_err=1, rdata=0, err_count=2.
- Issue store/load/store/load on 4 consecutive cycles to the same word: every cycle carries a response. Each load returns the value of the immediately preceding store.
- Use funct3=111 on a load and funct3=100 on a store → both give rsp_err=1. With ERR_CNT_WIDTH=2 and 5 errors, err_count saturates at 3.
- At DATA_WIDTH=64, SD 0x0123456789ABCDEF to 0x008, then LWU 0x00C → 0x0000000001234567. LW 0x008 → 0xFFFFFFFF89ABCDEF. Asserting rst the cycle after a load request gives rsp_valid=0, and the data is still readable after reset.
